// File: rtl/cnn_conv1_core_pkg.sv
// Shared sizing and arithmetic helpers for the stage-1 convolution core.
package cnn_conv1_core_pkg;

  localparam int unsigned IW     = 28;
  localparam int unsigned IH     = 28;
  localparam int unsigned KX     = 5;
  localparam int unsigned KY     = 5;
  localparam int unsigned CI     = 1;
  localparam int unsigned CO     = 3;
  localparam int unsigned I_F_BW = 8;
  localparam int unsigned W_BW   = 8;
  localparam int unsigned B_BW   = 16;
  localparam int unsigned O_F_BW = 24;

  localparam int unsigned OUT_W   = IW - KX + 1;
  localparam int unsigned OUT_H   = IH - KY + 1;
  localparam int unsigned NTAP    = CI * KX * KY;
  localparam int unsigned P_BW    = I_F_BW + W_BW + 1;
  localparam int unsigned WIN_BW  = NTAP * I_F_BW;
  localparam int unsigned WGT_BW  = CO * NTAP * W_BW;
  localparam int unsigned BIAS_BW = CO * B_BW;
  localparam int unsigned OUT_BW  = CO * O_F_BW;
  localparam int unsigned XW      = $clog2(IW);
  localparam int unsigned YW      = $clog2(IH);

  // Unsigned pixel times signed weight; the pixel gains a zero sign bit first.
  function automatic logic signed [P_BW-1:0] pix_mul(input logic [I_F_BW-1:0] pix,
                                                     input logic signed [W_BW-1:0] wgt);
    logic signed [I_F_BW:0] pix_s;
    pix_s = {1'b0, pix};
    return pix_s * wgt;
  endfunction

endpackage

// File: rtl/cnn_conv1_core_if.sv
// Pixel-in / feature-out stream bundle of the stage-1 convolution core.
interface cnn_conv1_core_if;
  import cnn_conv1_core_pkg::*;

  logic              i_in_valid;
  logic [I_F_BW-1:0] i_in_fmap;
  logic              o_ot_valid;
  logic [OUT_BW-1:0] o_ot_fmap;

  modport master (output i_in_valid, i_in_fmap, input o_ot_valid, o_ot_fmap);
  modport slave  (input i_in_valid, i_in_fmap, output o_ot_valid, o_ot_fmap);
endinterface

// File: rtl/cnn_window_buf.sv
// Line buffer, raster counters and 5x5 sliding window for the stage-1 conv core.
module cnn_window_buf
  import cnn_conv1_core_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid_i,
  input  logic [I_F_BW-1:0] in_pix_i,
  output logic [WIN_BW-1:0] window_o,
  output logic              window_valid_o
);

  localparam logic [XW-1:0] XLast  = XW'(IW - 1);
  localparam logic [YW-1:0] YLast  = YW'(IH - 1);
  localparam logic [XW-1:0] XFirst = XW'(KX - 1);
  localparam logic [YW-1:0] YFirst = YW'(KY - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  // win_q[ky][kx]: ky=KY-1 is the current row, kx=KX-1 the newest column.
  logic [KY-1:0][KX-1:0][I_F_BW-1:0] win_q, win_d;
  logic                              win_valid_q, win_valid_d;
  // Each entry holds column x of the previous KY-1 rows; index KY-2 is the most recent row.
  logic [KY-2:0][I_F_BW-1:0] lb_q [IW];
  logic [KY-2:0][I_F_BW-1:0] lb_rd;
  logic [KY-1:0][I_F_BW-1:0] col;

  assign lb_rd = lb_q[x_q];
  assign col   = {in_pix_i, lb_rd};

  // Raster position of the next accepted pixel; wraps to a new frame without a restart.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (in_valid_i) begin
      if (x_q == XLast) begin
        x_d = '0;
        y_d = (y_q == YLast) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Shift the freshly assembled column into the window; flag a full 5x5 neighbourhood.
  always_comb begin
    win_d       = win_q;
    win_valid_d = in_valid_i && (x_q >= XFirst) && (y_q >= YFirst);
    if (in_valid_i) begin
      for (int ky = 0; ky < KY; ky++) begin
        win_d[ky] = {col[ky], win_q[ky][KX-1:1]};
      end
    end
  end

  // Counter and window state with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x_q         <= '0;
      y_q         <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
    end
  end

  // Line-buffer write: drop the oldest row of this column, append the new pixel.
  always_ff @(posedge clk) begin
    if (in_valid_i) begin
      lb_q[x_q] <= col[KY-1:1];
    end
  end

  assign window_o       = win_q;
  assign window_valid_o = win_valid_q;

endmodule

// File: rtl/cnn_conv1_core.sv
// Stage-1 convolution engine: 5x5 valid conv, bias and ReLU for CO parallel channels.
module cnn_conv1_core
  import cnn_conv1_core_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WGT_BW-1:0]  i_cnn_weight,
  input  logic [BIAS_BW-1:0] i_cnn_bias,
  cnn_conv1_core_if.slave    strm_io
);

  logic [WIN_BW-1:0] window;
  logic              window_valid;

  cnn_window_buf u_window_buf (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid_i     (strm_io.i_in_valid),
    .in_pix_i       (strm_io.i_in_fmap),
    .window_o       (window),
    .window_valid_o (window_valid)
  );

  logic prod_valid_q, prod_valid_d;
  logic sum_valid_q, sum_valid_d;
  logic ot_valid_q, ot_valid_d;
  logic [CO-1:0][O_F_BW-1:0] ot_fmap;

  // Valid travels alongside the data; nothing stalls.
  always_comb begin
    prod_valid_d = window_valid;
    sum_valid_d  = prod_valid_q;
    ot_valid_d   = sum_valid_q;
  end

  // Pipeline valid registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prod_valid_q <= 1'b0;
      sum_valid_q  <= 1'b0;
      ot_valid_q   <= 1'b0;
    end else begin
      prod_valid_q <= prod_valid_d;
      sum_valid_q  <= sum_valid_d;
      ot_valid_q   <= ot_valid_d;
    end
  end

  for (genvar co = 0; co < CO; co++) begin : g_lane
    logic [NTAP-1:0][P_BW-1:0] prod_q, prod_d;
    logic signed [O_F_BW-1:0]  sum_q, sum_d;
    logic [O_F_BW-1:0]         ot_q, ot_d;

    // One multiply per window tap against this channel's kernel.
    always_comb begin
      prod_d = '0;
      for (int t = 0; t < NTAP; t++) begin
        prod_d[t] = pix_mul(window[t*I_F_BW +: I_F_BW],
                            i_cnn_weight[(co*NTAP + t)*W_BW +: W_BW]);
      end
    end

    // Adder tree seeded with the sign-extended bias.
    always_comb begin
      sum_d = O_F_BW'($signed(i_cnn_bias[co*B_BW +: B_BW]));
      for (int t = 0; t < NTAP; t++) begin
        sum_d = sum_d + O_F_BW'($signed(prod_q[t]));
      end
    end

    // ReLU into the output register, which holds between strobes.
    always_comb begin
      ot_d = ot_q;
      if (sum_valid_q) begin
        ot_d = sum_q[O_F_BW-1] ? '0 : sum_q;
      end
    end

    // Lane data registers.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        prod_q <= '0;
        sum_q  <= '0;
        ot_q   <= '0;
      end else begin
        prod_q <= prod_d;
        sum_q  <= sum_d;
        ot_q   <= ot_d;
      end
    end

    assign ot_fmap[co] = ot_q;
  end

  assign strm_io.o_ot_valid = ot_valid_q;
  assign strm_io.o_ot_fmap  = ot_fmap;

endmodule

// File: tb/tb_cnn_conv1_core.sv
// Directed-plus-random bench for cnn_conv1_core against a plain-arithmetic conv model.
module tb_cnn_conv1_core;
  import cnn_conv1_core_pkg::*;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [WGT_BW-1:0]  wgt;
  logic [BIAS_BW-1:0] bias;

  cnn_conv1_core_if bus ();

  cnn_conv1_core dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_cnn_weight (wgt),
    .i_cnn_bias   (bias),
    .strm_io      (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int                vectors     = 0;
  int                miscompares = 0;
  logic [OUT_BW-1:0] exp_q [$];
  logic [OUT_BW-1:0] mon_exp;
  int                strobe_cnt  = 0;
  int                first_cyc   = -1;
  int                mark_cyc    = 0;
  bit                ignore      = 1'b1;
  int                frame_a [IW*IH];
  int                frame_b [IW*IH];

  // Every output strobe is checked against the next expected result.
  always @(negedge clk) begin
    if (!ignore && bus.o_ot_valid === 1'b1) begin
      strobe_cnt++;
      if (first_cyc < 0) first_cyc = cyc;
      vectors++;
      assert (exp_q.size() > 0) else begin
        miscompares++;
        $error("FAIL unexpected_strobe: observed strobe at cycle %0d, required none", cyc);
      end
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        assert (bus.o_ot_fmap === mon_exp) else begin
          miscompares++;
          $error("FAIL strobe_%0d: observed %h required %h", strobe_cnt, bus.o_ot_fmap, mon_exp);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [OUT_BW-1:0] obs,
                       input logic [OUT_BW-1:0] req);
    vectors++;
    assert (obs === req) else begin
      miscompares++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, req);
    end
  endtask

  // Reference: direct sum over the kernel for every output position, raster order.
  function automatic void push_model(input int f [IW*IH]);
    logic [OUT_BW-1:0] v;
    int acc;
    for (int oy = 0; oy < OUT_H; oy++) begin
      for (int ox = 0; ox < OUT_W; ox++) begin
        v = '0;
        for (int co = 0; co < CO; co++) begin
          acc = int'($signed(bias[co*B_BW +: B_BW]));
          for (int ky = 0; ky < KY; ky++) begin
            for (int kx = 0; kx < KX; kx++) begin
              acc += f[(oy+ky)*IW + ox + kx] *
                     int'($signed(wgt[(co*NTAP + ky*KX + kx)*W_BW +: W_BW]));
            end
          end
          if (acc < 0) acc = 0;
          v[co*O_F_BW +: O_F_BW] = O_F_BW'(acc);
        end
        exp_q.push_back(v);
      end
    end
  endfunction

  task automatic push_const(input logic [OUT_BW-1:0] v);
    repeat (OUT_W*OUT_H) exp_q.push_back(v);
  endtask

  task automatic drive_pixels(input int f [IW*IH], input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(1, 0) == 1) begin
          bus.i_in_valid = 1'b0;
          bus.i_in_fmap  = I_F_BW'($urandom);
          @(posedge clk); #1;
        end
      end
      bus.i_in_valid = 1'b1;
      bus.i_in_fmap  = I_F_BW'(f[i]);
      if (i == (KY-1)*IW + (KX-1)) mark_cyc = cyc;
      @(posedge clk); #1;
    end
    bus.i_in_valid = 1'b0;
  endtask

  task automatic start_test();
    strobe_cnt = 0;
    first_cyc  = -1;
  endtask

  task automatic finish_test(input string tag, input int n_strobes);
    int n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (8) @(posedge clk);
    #1;
    check({tag, "_count"}, OUT_BW'(strobe_cnt), OUT_BW'(n_strobes));
    check({tag, "_pending"}, OUT_BW'(exp_q.size()), '0);
  endtask

  task automatic randomize_params();
    for (int i = 0; i < WGT_BW/W_BW; i++) wgt[i*W_BW +: W_BW] = W_BW'($urandom);
    for (int i = 0; i < CO; i++) bias[i*B_BW +: B_BW] = B_BW'($urandom);
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.i_in_valid = 1'b0;
    bus.i_in_fmap  = '0;
    wgt            = '0;
    bias           = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", OUT_BW'(bus.o_ot_valid), '0);
    check("reset_fmap", bus.o_ot_fmap, '0);
    reset_n = 1'b1;
    ignore  = 1'b0;

    // All-ones kernel over a flat frame.
    for (int i = 0; i < WGT_BW/W_BW; i++) wgt[i*W_BW +: W_BW] = 8'd1;
    bias = '0;
    foreach (frame_a[i]) frame_a[i] = 1;
    push_const({3{24'd25}});
    start_test();
    drive_pixels(frame_a, IW*IH, 1'b0);
    finish_test("ones", 576);
    check("ones_latency", OUT_BW'(first_cyc - mark_cyc), 4);

    // Centre tap only on ch0, ramp frame: output is the shifted ramp plus bias.
    wgt = '0;
    wgt[(2*KX + 2)*W_BW +: W_BW] = 8'd1;
    bias = '0;
    bias[0 +: B_BW] = 16'd10;
    foreach (frame_a[i]) frame_a[i] = i % 256;
    for (int oy = 0; oy < OUT_H; oy++) begin
      for (int ox = 0; ox < OUT_W; ox++) begin
        logic [OUT_BW-1:0] v;
        v = '0;
        v[O_F_BW-1:0] = O_F_BW'(((ox + 2) + (oy + 2)*IW) % 256 + 10);
        exp_q.push_back(v);
      end
    end
    start_test();
    drive_pixels(frame_a, IW*IH, 1'b0);
    finish_test("centre", 576);

    // Most negative extreme clamps to zero.
    for (int i = 0; i < WGT_BW/W_BW; i++) wgt[i*W_BW +: W_BW] = 8'h80;
    for (int i = 0; i < CO; i++) bias[i*B_BW +: B_BW] = 16'h8000;
    foreach (frame_a[i]) frame_a[i] = 255;
    push_const('0);
    start_test();
    drive_pixels(frame_a, IW*IH, 1'b0);
    finish_test("min_relu", 576);

    // Most positive extreme.
    for (int i = 0; i < WGT_BW/W_BW; i++) wgt[i*W_BW +: W_BW] = 8'd127;
    for (int i = 0; i < CO; i++) bias[i*B_BW +: B_BW] = 16'h7fff;
    push_const({3{24'd842392}});
    start_test();
    drive_pixels(frame_a, IW*IH, 1'b0);
    finish_test("max_sum", 576);

    // Same random frame streamed continuously, then with random idle gaps.
    randomize_params();
    foreach (frame_a[i]) frame_a[i] = int'($urandom_range(255, 0));
    push_model(frame_a);
    push_model(frame_a);
    start_test();
    drive_pixels(frame_a, IW*IH, 1'b0);
    drive_pixels(frame_a, IW*IH, 1'b1);
    finish_test("gaps", 1152);

    // Two different frames back to back with no idle cycle between them.
    randomize_params();
    foreach (frame_a[i]) frame_a[i] = int'($urandom_range(255, 0));
    foreach (frame_b[i]) frame_b[i] = int'($urandom_range(255, 0));
    push_model(frame_a);
    push_model(frame_b);
    start_test();
    drive_pixels(frame_a, IW*IH, 1'b0);
    drive_pixels(frame_b, IW*IH, 1'b0);
    finish_test("b2b", 1152);

    // Abandon a frame with a one-cycle reset, then stream a complete one.
    randomize_params();
    foreach (frame_a[i]) frame_a[i] = int'($urandom_range(255, 0));
    ignore = 1'b1;
    drive_pixels(frame_a, 300, 1'b0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    ignore = 1'b0;
    check("midreset_valid", OUT_BW'(bus.o_ot_valid), '0);
    check("midreset_fmap", bus.o_ot_fmap, '0);
    reset_n = 1'b1;
    foreach (frame_b[i]) frame_b[i] = int'($urandom_range(255, 0));
    push_model(frame_b);
    start_test();
    drive_pixels(frame_b, IW*IH, 1'b0);
    finish_test("after_reset", 576);
    check("after_reset_latency", OUT_BW'(first_cyc - mark_cyc), 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
